// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared funct3 codes and FSM state encoding
// Contents:
//   F3_B/F3_H/F3_W/F3_BU/F3_HU : RV32I load/store funct3 size/sign codes
//   state_e                    : responder FSM states
package mem_resp_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request/response bus
// Signals:
//   req_valid/req_ready           : request handshake
//   req_we/req_addr/req_wdata/req_funct3 : request payload
//   rsp_valid/rsp_ready           : response handshake
//   rsp_rdata/rsp_err             : response payload
// Modports: master = requester (datapath), slave = responder.
interface data_mem_responder_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/data_mem_responder_lane_align.sv
// rtl/data_mem_responder_lane_align.sv - byte-lane steering for RV32I loads/stores
// Ports:
//   we, funct3, lane : access kind, size/sign and byte offset addr[1:0]
//   wdata            : right-aligned store data
//   rword            : word read from the array at the addressed index
//   wmask, wword     : byte write enables and lane-shifted store word
//   rdata            : extracted, sign/zero-extended load result
//   misalign         : half on odd byte or word not on a word boundary
//   bad_size         : funct3 not legal for this access kind
module mem_lane_align
   import mem_resp_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  wmask,
   output logic [31:0] wword,
   output logic [31:0] rdata,
   output logic        misalign,
   output logic        bad_size
);

   logic [4:0]  shamt;
   logic [31:0] rshift;

   assign shamt  = {lane, 3'b000};
   assign rshift = rword >> shamt;

   always_comb begin
      wmask    = 4'b0000;
      wword    = wdata << shamt;
      rdata    = 32'h0;
      misalign = 1'b0;
      bad_size = 1'b0;
      case (funct3)
         F3_B: begin
            wmask = 4'b0001 << lane;
            rdata = {{24{rshift[7]}}, rshift[7:0]};
         end
         F3_H: begin
            wmask    = 4'b0011 << lane;
            rdata    = {{16{rshift[15]}}, rshift[15:0]};
            misalign = lane[0];
         end
         F3_W: begin
            wmask    = 4'b1111;
            rdata    = rword;
            misalign = (lane != 2'b00);
         end
         // Unsigned variants exist only for loads.
         F3_BU: begin
            rdata    = {24'h0, rshift[7:0]};
            bad_size = we;
         end
         F3_HU: begin
            rdata    = {16'h0, rshift[15:0]};
            misalign = lane[0];
            bad_size = we;
         end
         default: bad_size = 1'b1;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency load/store responder with internal word RAM
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (array contents are kept)
//   bus  : data_mem_responder_if.slave request/response bus
// Parameters:
//   DEPTH_WORDS : 32-bit words in the array
//   LATENCY     : WAIT cycles between acceptance and response (0 allowed)
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
)
(
   input  logic clk,
   input  logic rst,
   data_mem_responder_if.slave bus
);

   localparam int          AW         = $clog2(DEPTH_WORDS);
   localparam int          CW         = $clog2(LATENCY + 2);
   localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;
   localparam logic [1:0]  ST_IDLE    = S_IDLE;
   localparam logic [1:0]  ST_WAIT    = S_WAIT;
   localparam logic [1:0]  ST_RESP    = S_RESP;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [2:0]    f3_q, f3_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;

   logic [31:0]   mem [DEPTH_WORDS];

   logic          in_idle, go_resp, do_write, err_now, out_of_range;
   logic          cur_we;
   logic [31:0]   cur_addr, cur_wdata;
   logic [2:0]    cur_f3;
   logic [AW-1:0] widx;
   logic [31:0]   rword, wword, ld_data;
   logic [3:0]    wmask;
   logic          misalign, bad_size;

   // With LATENCY==0 the response is produced on the acceptance edge, before
   // the request latches are loaded, so the access is evaluated from the live
   // bus while idle and from the latches otherwise.
   assign in_idle   = (state_q == ST_IDLE);
   assign cur_we    = in_idle ? bus.req_we     : we_q;
   assign cur_addr  = in_idle ? bus.req_addr   : addr_q;
   assign cur_wdata = in_idle ? bus.req_wdata  : wdata_q;
   assign cur_f3    = in_idle ? bus.req_funct3 : f3_q;

   assign widx         = cur_addr[AW+1:2];
   assign rword        = mem[widx];
   assign out_of_range = ({1'b0, cur_addr} >= BYTE_LIMIT);

   mem_lane_align u_align (
      .we       (cur_we),
      .funct3   (cur_f3),
      .lane     (cur_addr[1:0]),
      .wdata    (cur_wdata),
      .rword    (rword),
      .wmask    (wmask),
      .wword    (wword),
      .rdata    (ld_data),
      .misalign (misalign),
      .bad_size (bad_size)
   );

   assign err_now  = misalign | bad_size | out_of_range;
   assign do_write = go_resp & cur_we & ~err_now;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      f3_d        = f3_q;
      rsp_valid_d = rsp_valid_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      go_resp     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               f3_d    = bus.req_funct3;
               cnt_d   = CW'(LATENCY);
               if (LATENCY == 0) go_resp = 1'b1;
               else              state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == CW'(1)) go_resp = 1'b1;
            else                 cnt_d   = cnt_q - CW'(1);
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (go_resp) begin
         state_d     = ST_RESP;
         rsp_valid_d = 1'b1;
         err_d       = err_now;
         rdata_d     = (err_now || cur_we) ? 32'h0 : ld_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         f3_q        <= 3'b000;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         f3_q        <= f3_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (wmask[i]) mem[widx][8*i +: 8] <= wword[8*i +: 8];
         end
      end
   end

   assign bus.req_ready = in_idle;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;
   import mem_resp_pkg::*;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   bit          sel = 1'b0;
   int          lat = 2;

   logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic [2:0]  req_funct3 = 3'b000;

   logic        m_req_ready, m_rsp_valid, m_rsp_err;
   logic [31:0] m_rsp_rdata;

   data_mem_responder_if if0();
   data_mem_responder_if if1();

   assign if0.req_valid  = req_valid & ~sel;
   assign if1.req_valid  = req_valid & sel;
   assign if0.req_we     = req_we;     assign if1.req_we     = req_we;
   assign if0.req_addr   = req_addr;   assign if1.req_addr   = req_addr;
   assign if0.req_wdata  = req_wdata;  assign if1.req_wdata  = req_wdata;
   assign if0.req_funct3 = req_funct3; assign if1.req_funct3 = req_funct3;
   assign if0.rsp_ready  = rsp_ready;  assign if1.rsp_ready  = rsp_ready;

   assign m_req_ready = sel ? if1.req_ready : if0.req_ready;
   assign m_rsp_valid = sel ? if1.rsp_valid : if0.rsp_valid;
   assign m_rsp_rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;
   assign m_rsp_err   = sel ? if1.rsp_err   : if0.rsp_err;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   always #5 clk = ~clk;

   int          n_cmp = 0, n_bad = 0;
   bit          busy = 1'b0;
   int          k = 0;
   logic [31:0] exp_rd;
   logic        exp_err;
   logic [7:0]  mdl [int];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no DUT event within cycle budget (t=%0t)", nm, $time);
   endtask

   // Byte-addressed reference memory: legality from the funct3 table, then
   // little-endian byte assembly and extension.
   function automatic void model_eval(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                      input logic [2:0] f3, output logic [31:0] rd, output logic e);
      int nb;
      bit legal;
      legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                 : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      nb = 1 << f3[1:0];
      e  = !legal || ((int'(a[1:0]) % nb) != 0) || (a >= 32'(4 * DEPTH));
      rd = 32'h0;
      if (!e) begin
         if (we) begin
            for (int i = 0; i < nb; i++) mdl[int'(a) + i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < nb; i++)
               rd[8*i +: 8] = mdl.exists(int'(a) + i) ? mdl[int'(a) + i] : 8'hxx;
            for (int i = nb; i < 4; i++)
               rd[8*i +: 8] = (!f3[2] && rd[8*nb-1]) ? 8'hFF : 8'h00;
         end
      end
   endfunction

   // Every-cycle comparison against the model's expectation.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy) begin
            check("busy_req_ready", {31'h0, m_req_ready}, 32'h0);
            if (k < lat) begin
               check("early_rsp_valid", {31'h0, m_rsp_valid}, 32'h0);
            end else begin
               check("rsp_valid", {31'h0, m_rsp_valid}, 32'h1);
               check("rsp_rdata", m_rsp_rdata, exp_rd);
               check("rsp_err", {31'h0, m_rsp_err}, {31'h0, exp_err});
            end
            k++;
         end else begin
            check("idle_req_ready", {31'h0, m_req_ready}, 32'h1);
            check("idle_rsp_valid", {31'h0, m_rsp_valid}, 32'h0);
         end
      end
   end

   task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input logic [31:0] lit_rd, input logic lit_e,
                         input int hold);
      int t;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
      rsp_ready = (hold == 0);
      t = 0;
      while (!m_req_ready && t < 20) begin @(negedge clk); t++; end
      if (!m_req_ready) begin fail_now("accept_timeout"); req_valid = 1'b0; return; end
      @(posedge clk);
      model_eval(we, a, wd, f3, exp_rd, exp_err);
      busy = 1'b1;
      k = 0;
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      req_funct3 = 3'($urandom);
      t = 0;
      while (t < 30) begin
         @(negedge clk);
         t++;
         if (m_rsp_valid) break;
      end
      if (!m_rsp_valid) begin fail_now("rsp_timeout"); busy = 1'b0; rsp_ready = 1'b1; return; end
      check("lit_rdata", m_rsp_rdata, lit_rd);
      check("lit_err", {31'h0, m_rsp_err}, {31'h0, lit_e});
      for (int i = 0; i < hold - 1; i++) begin
         @(negedge clk);
         req_valid = ~req_valid; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0;
         req_funct3 = F3_W;
      end
      if (hold > 0) @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      busy = 1'b0;
   endtask

   task automatic abort_req(input logic [31:0] a, input logic [31:0] wd, input bit committed);
      int t;
      logic [31:0] rd_dummy;
      logic        e_dummy;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = wd; req_funct3 = F3_W;
      t = 0;
      while (!m_req_ready && t < 20) begin @(negedge clk); t++; end
      if (!m_req_ready) begin fail_now("abort_accept_timeout"); req_valid = 1'b0; return; end
      @(posedge clk);
      if (committed) begin
         model_eval(1'b1, a, wd, F3_W, rd_dummy, e_dummy);
      end
      exp_rd = 32'h0;
      exp_err = 1'b0;
      busy = 1'b1;
      k = 0;
      #1 req_valid = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      busy = 1'b0;
      #1;
      check("rst_req_ready", {31'h0, m_req_ready}, 32'h1);
      check("rst_rsp_valid", {31'h0, m_rsp_valid}, 32'h0);
      check("rst_rsp_rdata", m_rsp_rdata, 32'h0);
      check("rst_rsp_err", {31'h0, m_rsp_err}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         check("reset_req_ready", {31'h0, m_req_ready}, 32'h1);
         check("reset_rsp_valid", {31'h0, m_rsp_valid}, 32'h0);
         check("reset_rsp_rdata", m_rsp_rdata, 32'h0);
         check("reset_rsp_err", {31'h0, m_rsp_err}, 32'h0);
      end
      sel = 1'b0;
      lat = 2;
      @(negedge clk);
      rst = 1'b0;

      // LATENCY = 2 instance
      do_req(1'b1, 32'h10, 32'hDEADBEEF, F3_W,  32'h0,        1'b0, 0);
      do_req(1'b0, 32'h10, 32'h0,        F3_W,  32'hDEADBEEF, 1'b0, 0);
      do_req(1'b0, 32'h13, 32'h0,        F3_B,  32'hFFFFFFDE, 1'b0, 0);
      do_req(1'b0, 32'h13, 32'h0,        F3_BU, 32'h000000DE, 1'b0, 0);
      do_req(1'b0, 32'h10, 32'h0,        F3_H,  32'hFFFFBEEF, 1'b0, 0);
      do_req(1'b0, 32'h12, 32'h0,        F3_HU, 32'h0000DEAD, 1'b0, 0);
      do_req(1'b1, 32'h11, 32'h00000055, F3_B,  32'h0,        1'b0, 0);
      do_req(1'b0, 32'h10, 32'h0,        F3_W,  32'hDEAD55EF, 1'b0, 0);
      do_req(1'b0, 32'h12, 32'h0,        F3_W,  32'h0,        1'b1, 0);
      do_req(1'b1, 32'h13, 32'h0000AAAA, F3_H,  32'h0,        1'b1, 0);
      do_req(1'b0, 32'h10, 32'h0,        3'b011, 32'h0,       1'b1, 0);
      do_req(1'b0, 32'h1000, 32'h0,      F3_W,  32'h0,        1'b1, 0);
      do_req(1'b1, 32'h10, 32'h11111111, F3_BU, 32'h0,        1'b1, 0);
      do_req(1'b1, 32'h80000010, 32'h22222222, F3_W, 32'h0,   1'b1, 0);
      do_req(1'b0, 32'h10, 32'h0,        F3_W,  32'hDEAD55EF, 1'b0, 0);
      do_req(1'b0, 32'h10, 32'h0,        F3_W,  32'hDEAD55EF, 1'b0, 5);
      do_req(1'b0, 32'h10, 32'h0,        F3_W,  32'hDEAD55EF, 1'b0, 0);
      do_req(1'b1, 32'h20, 32'hCAFEF00D, F3_W,  32'h0,        1'b0, 0);
      do_req(1'b0, 32'h20, 32'h0,        F3_W,  32'hCAFEF00D, 1'b0, 0);
      abort_req(32'h20, 32'h12345678, 1'b0);
      do_req(1'b0, 32'h20, 32'h0,        F3_W,  32'hCAFEF00D, 1'b0, 0);

      // LATENCY = 0 instance, back-to-back handshakes
      @(negedge clk);
      sel = 1'b1;
      lat = 0;
      mdl.delete();
      do_req(1'b1, 32'h40, 32'h89ABCDEF, F3_W,  32'h0,        1'b0, 0);
      do_req(1'b0, 32'h40, 32'h0,        F3_W,  32'h89ABCDEF, 1'b0, 0);
      do_req(1'b0, 32'h42, 32'h0,        F3_H,  32'hFFFF89AB, 1'b0, 0);
      do_req(1'b0, 32'h41, 32'h0,        F3_B,  32'hFFFFFFCD, 1'b0, 0);
      do_req(1'b0, 32'h41, 32'h0,        F3_W,  32'h0,        1'b1, 0);
      do_req(1'b1, 32'h43, 32'h000000A5, F3_B,  32'h0,        1'b0, 0);
      do_req(1'b0, 32'h40, 32'h0,        F3_W,  32'hA5ABCDEF, 1'b0, 3);
      abort_req(32'h40, 32'h12345678, 1'b1);
      do_req(1'b0, 32'h40, 32'h0,        F3_W,  32'h12345678, 1'b0, 0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
